mul_operand_issuer: RTL and testbench

Upstream operand feeder for the shift-add pipelined multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a DEPTH-entry FIFO. It issues one pair at a time to the multiplier with a single-cycle `mul_start` pulse. It holds `mul_a` and `mul_b` stable until the multiplier raises `valid`; this is mandatory because the multiplier samples `b` on every stage rather than latching it at start.

---
 rtl/mul_operand_issuer.sv | 106 ++++++++++
 tb/tb_mul_operand_issuer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_issuer.sv
// Operand feeder for the shift-add multiplier. It buffers operand pairs in a small FIFO and
// issues them one at a time, holding each pair stable until the multiplier reports valid.
module mul_operand_issuer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic [15:0]              done_count
);

  // state | meaning
  // IDLE  | nothing in flight, waiting for the FIFO to hold a pair
  // ISSUE | mul_start high for this one cycle, operands already loaded
  // WAIT  | multiplier running; operands held until mul_valid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  state_t            state;
  logic [WIDTH-1:0]  mem_a [DEPTH];
  logic [WIDTH-1:0]  mem_b [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  cur_a;
  logic [WIDTH-1:0]  cur_b;
  logic              push;
  logic              load;
  logic              have_data;

  assign in_ready  = count < FULL;
  assign push      = in_valid && in_ready;
  assign have_data = count != '0;
  // A pop only happens when the head is loaded into cur_a/cur_b.
  assign load      = have_data && ((state == IDLE) || (state == WAIT && mul_valid));

  assign mul_start = state == ISSUE;
  assign mul_a     = cur_a;
  assign mul_b     = cur_b;
  assign busy      = (state != IDLE) || have_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_a      <= '0;
      cur_b      <= '0;
      done_count <= '0;
    end else begin
      if (load) begin
        cur_a <= mem_a[rd_ptr];
        cur_b <= mem_b[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (have_data) state <= ISSUE;
        end
        // mul_valid may still be high from the previous product; ignore it here.
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            done_count <= done_count + 16'd1;
            state      <= have_data ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_issuer.sv
// Bench for mul_operand_issuer: behavioural multiplier model, push-time scoreboard,
// table-driven burst plus hand-written timing and reset sequences.
module tb_mul_operand_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_valid;
  logic [2:0]  count;
  logic        busy;
  logic [15:0] done_count;

  always #5 clk = ~clk;

  mul_operand_issuer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_valid  (mul_valid),
    .count      (count),
    .busy       (busy),
    .done_count (done_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Multiplier model: start sampled at an edge, valid drops next cycle and
  // rises 9 cycles after the start cycle, then stays high until the next start.
  logic [15:0] mul_p;
  logic [7:0]  lat_a;
  logic [7:0]  lat_b;
  logic        res_new;
  int          m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_valid <= 1'b0;
      mul_p     <= '0;
      res_new   <= 1'b0;
      m_cnt     <= 0;
      lat_a     <= '0;
      lat_b     <= '0;
    end else begin
      res_new <= 1'b0;
      if (m_cnt > 0) begin
        check("operand_a_held", mul_a, lat_a);
        check("operand_b_held", mul_b, lat_b);
        check("no_start_while_busy", mul_start, 0);
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          mul_valid <= 1'b1;
          mul_p     <= 16'(lat_a) * 16'(lat_b);
          res_new   <= 1'b1;
        end
      end else if (mul_start) begin
        m_cnt     <= 8;
        mul_valid <= 1'b0;
        lat_a     <= mul_a;
        lat_b     <= mul_b;
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t        sb_q[$];
  vec_t        sb_e;
  logic [15:0] in_exp;
  int          last_start;
  bit          spacing_on;
  int          max_count;
  bit          saw_not_ready;

  // Scoreboard: record accepted pairs, compare each product as it appears.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb_e.a = in_a;
        sb_e.b = in_b;
        sb_e.p = in_exp;
        sb_q.push_back(sb_e);
      end
      if (res_new) begin
        check("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          sb_e = sb_q.pop_front();
          check("product", mul_p, sb_e.p);
          check("mul_a_at_valid", mul_a, sb_e.a);
          check("mul_b_at_valid", mul_b, sb_e.b);
        end
      end
      if (mul_start) begin
        if (spacing_on && last_start >= 0) check("start_spacing", cyc - last_start, 10);
        last_start = cyc;
      end
      if (int'(count) > max_count) max_count = int'(count);
      if (!in_ready) saw_not_ready = 1'b1;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done_count"}, done_count, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p, input bit keep);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_exp   = p;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int max_cyc);
    int n;
    n = 0;
    while (int'(done_count) != target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, done_count, target);
  endtask

  vec_t tbl[6];
  int   t0;
  int   base;
  int   n_start;
  int   n;
  bit   hold_ok;

  initial begin
    tbl[0] = '{8'h01, 8'h01, 16'h0001};
    tbl[1] = '{8'h02, 8'h03, 16'h0006};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[3] = '{8'h00, 8'h55, 16'h0000};
    tbl[4] = '{8'h80, 8'h02, 16'h0100};
    tbl[5] = '{8'h07, 8'h09, 16'h003F};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_exp = '0;
    last_start = -1; spacing_on = 1'b0; max_count = 0; saw_not_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk); reset = 1'b0;

    // Single operation with exact cycle timing.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'h0D; in_b = 8'h0B; in_exp = 16'h008F;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("single_cycle_index_%0d", k), cyc - t0, k);
      check($sformatf("single_start_c%0d", k), mul_start, int'(k == 2));
      if (k == 1) check("single_count_c1", count, 1);
      if (k >= 2 && k <= 11 && (mul_a != 8'h0D || mul_b != 8'h0B)) hold_ok = 1'b0;
      if (k == 11) begin
        check("single_valid_c11", mul_valid, 1);
        check("single_product_c11", mul_p, 16'h008F);
        check("single_busy_c11", busy, 1);
      end
      if (k == 12) check("single_done_c12", done_count, 1);
      if (k == 13) check("single_busy_c13", busy, 0);
    end
    check("single_operands_held", hold_ok, 1);

    // Stale valid: mul_valid is still high when the next pair is issued.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stale_valid_high", mul_valid, 1);
    push_pair(8'h05, 8'h06, 16'h001E, 1'b0);
    wait_done("stale_done", 2, 40);
    repeat (12) @(posedge clk);
    #1;
    check("stale_single_increment", done_count, 2);

    // Table-driven burst with in_valid held high.
    base = int'(done_count);
    spacing_on = 1'b1; last_start = -1; max_count = 0; saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_pair(tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);
    in_valid = 1'b0;
    wait_done("burst_done", base + 6, 200);
    check("burst_saw_not_ready", saw_not_ready, 1);
    check("burst_max_count", max_count, 4);
    spacing_on = 1'b0;

    // New input while the first pair is in WAIT must not disturb its operands.
    base = int'(done_count);
    push_pair(8'h21, 8'h03, 16'h0063, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("stability_mid_wait_a", mul_a, 8'h21);
    push_pair(8'h44, 8'h55, 16'h1694, 1'b0);
    check("stability_mid_wait_b", mul_b, 8'h03);
    wait_done("stability_done", base + 2, 60);

    // Push on the same edge as a WAIT pop with count == 2.
    base = int'(done_count);
    push_pair(8'h11, 8'h02, 16'h0022, 1'b1);
    push_pair(8'h03, 8'h05, 16'h000F, 1'b1);
    push_pair(8'h10, 8'h10, 16'h0100, 1'b0);
    n = 0;
    while (!(mul_valid && !mul_start && count == 3'd2) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("simul_reached_wait_valid", int'(n < 40), 1);
    in_valid = 1'b1; in_a = 8'h0A; in_b = 8'h0C; in_exp = 16'h0078;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("simul_count_unchanged", count, 2);
    check("simul_restarted", mul_start, 1);
    wait_done("simul_done", base + 4, 200);

    // Reset in the middle of WAIT with three pairs queued.
    push_pair(8'h01, 8'h02, 16'h0002, 1'b1);
    push_pair(8'h03, 8'h04, 16'h000C, 1'b1);
    push_pair(8'h05, 8'h06, 16'h001E, 1'b1);
    push_pair(8'h07, 8'h08, 16'h0038, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_count_before", count, 3);
    check("midreset_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    n_start = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mul_start) n_start++;
    end
    check("midreset_no_start", n_start, 0);
    check("midreset_done_zero", done_count, 0);
    push_pair(8'h09, 8'h09, 16'h0051, 1'b0);
    wait_done("after_reset_done", 1, 40);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
